// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART receive FIFO      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2,
        GAP     = 2'd3
    } rx_state_t;

    // rx_clr stays low this long so the receiver's edge detector re-arms
    localparam int GAP_CYCLES = 2;

    typedef logic [$clog2(GAP_CYCLES)-1:0] gap_cnt_t;
    localparam gap_cnt_t GAP_LAST = gap_cnt_t'(GAP_CYCLES - 1);

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo_if : receiver handshake and host pop/status bundle      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) ();

    byte_t               rx_data;
    logic                rx_ready;
    logic                rx_clr;
    logic                rd;
    byte_t               dout;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overrun;
    logic                ovr_clr;
    logic                irq;

    modport slave (
        input  rx_data, rx_ready, rd, ovr_clr,
        output rx_clr, dout, empty, full, count, overrun, irq
    );

    modport master (
        output rx_data, rx_ready, rd, ovr_clr,
        input  rx_clr, dout, empty, full, count, overrun, irq
    );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo_ram : 2**DEPTH_LOG2 x 8 storage, sync write, async read    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [DEPTH_LOG2-1:0] waddr,
    input  wire byte_t                 wdata,
    input  wire logic [DEPTH_LOG2-1:0] raddr,
    output byte_t                      rdata
);

    byte_t r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo : receiver acknowledge FSM feeding a fall-through FIFO  |
// | Option   : define UART_RX_FIFO_IRQ_EN for the registered level irq   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    uart_rx_fifo_if.slave bus
);

    localparam int                  c_DEPTH    = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_CNT_FULL = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    rx_state_t             r_state;
    rx_state_t             w_state_next;
    gap_cnt_t              r_gap_cnt;
    gap_cnt_t              w_gap_cnt_next;
    logic                  r_rx_clr;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overrun;
    byte_t                 w_dout;

    assign w_pop = bus.rd && !r_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_rx_clr  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_rx_clr  <= (w_state_next == ACK);
        end
    end

    // A pop in the capture cycle frees the slot, so a full FIFO still accepts
    always_comb begin
        w_state_next   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        w_push         = 1'b0;
        w_drop         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.rx_ready) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!r_full || w_pop) begin
                    w_push = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
                w_state_next = ACK;
            end
            ACK: begin
                if (!bus.rx_ready) begin
                    w_state_next   = GAP;
                    w_gap_cnt_next = '0;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + gap_cnt_t'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == c_CNT_FULL);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (bus.rx_data),
        .raddr (r_rd_ptr),
        .rdata (w_dout)
    );

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [DEPTH_LOG2:0] c_IRQ_LEVEL = (DEPTH_LOG2+1)'(IRQ_LEVEL);
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_count >= c_IRQ_LEVEL) | r_overrun;
        end
    end

    assign bus.irq = r_irq;
`else
    assign bus.irq = 1'b0;
`endif

    assign bus.rx_clr  = r_rx_clr;
    assign bus.dout    = w_dout;
    assign bus.empty   = r_empty;
    assign bus.full    = r_full;
    assign bus.count   = r_count;
    assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter IRQ_LEVEL, default 1, meaning the occupancy at or above which irq asserts.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8, byte from the UART receiver, valid while rx_ready=1.
REQ-006 SHALL have port rx_ready, input, 1, receiver byte-available level.
REQ-007 SHALL have port rx_clr, output, 1, acknowledge to receiver; the receiver clears rx_ready on its rising edge after 2-flop sampling.
REQ-008 SHALL have port rd, input, 1, host pop strobe, one byte per cycle high.
REQ-009 SHALL have port dout, output, 8, head-of-FIFO byte (first-word fall-through).
REQ-010 SHALL have ports empty, full, each output, 1, occupancy flags.
REQ-011 SHALL have port count, output, DEPTH_LOG2+1, current occupancy.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a dropped byte.
REQ-013 SHALL have port ovr_clr, input, 1, clears overrun.
REQ-014 SHALL have port irq, output, 1, level interrupt (see Configuration).

Function
REQ-015 SHALL run the acknowledge FSM through IDLE -> CAPTURE -> ACK -> GAP -> IDLE.
REQ-016 In IDLE with rx_ready=1, SHALL move to CAPTURE; otherwise SHALL stay in IDLE.
REQ-017 In CAPTURE (one cycle), SHALL push rx_data if space is available, else SHALL set overrun and drop the byte; SHALL move to ACK.
REQ-018 In ACK, SHALL drive rx_clr=1 until rx_ready is sampled 0, then SHALL move to GAP.
REQ-019 In GAP, SHALL hold rx_clr=0 for exactly 2 cycles, so the receiver edge detector re-arms, then SHALL return to IDLE.
REQ-020 rx_clr SHALL be registered, high only in ACK; each received byte SHALL be pushed exactly once.
REQ-021 rd with empty=0 SHALL pop the head; the new head SHALL appear on dout the next cycle.
REQ-022 rd with empty=1 SHALL be ignored, with no change to pointers, count or flags.
REQ-023 Push and pop in the same cycle SHALL both take effect with count unchanged, including when full (the pop frees space first).
REQ-024 Pointers SHALL wrap modulo 2**DEPTH_LOG2.
REQ-025 full SHALL equal (count == 2**DEPTH_LOG2); empty SHALL equal (count == 0); both SHALL be registered and consistent with count in the same cycle.
REQ-026 overrun SHALL be set on a dropped byte and cleared by ovr_clr; if both occur in the same cycle, set SHALL win.
REQ-027 dout SHALL be don't-care while empty=1.

Reset
REQ-028 Reset SHALL force FSM=IDLE, rx_clr=0, pointers=0, count=0, empty=1, full=0, overrun=0, irq=0.
REQ-029 Reset asserted mid-handshake SHALL abandon the byte, and rx_clr SHALL drop immediately.
REQ-030 On reset release with rx_ready=1, SHALL capture that byte normally.

Configuration
REQ-031 With UART_RX_FIFO_IRQ_EN defined, irq SHALL be registered and equal to (count >= IRQ_LEVEL) | overrun, updated one cycle after count or overrun changes.
REQ-032 With UART_RX_FIFO_IRQ_EN undefined, irq SHALL be tied 0 and no comparator logic SHALL exist.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state enum (IDLE, CAPTURE, ACK, GAP), the GAP_CYCLES=2 constant and the byte typedef.
REQ-034 Storage SHALL be a sub-module uart_fifo_ram: 2**DEPTH_LOG2 x 8, synchronous write, asynchronous read by read pointer.

Verification
REQ-035 Send 0x55, 0xA3 through a receiver model -> count=2, dout=0x55; after rd, dout=0xA3; after rd, empty=1; each byte sees exactly one rx_clr rising edge.
REQ-036 Send 17 bytes 0x00..0x10 with no rd at DEPTH_LOG2=4 -> full=1, count=16, overrun=1; pop order 0x00..0x0F; 0x10 is lost.
REQ-037 When full, push and rd in the same cycle -> count stays 16, no overrun, popped head correct.
REQ-038 rd while empty, and ovr_clr coinciding with a new drop -> no state change on the empty read; overrun remains 1 after the coincident cycle.
REQ-039 Assert reset during ACK -> rx_clr=0 next edge, count=0; the following byte is captured once.
REQ-040 With UART_RX_FIFO_IRQ_EN and IRQ_LEVEL=3 -> irq rises one cycle after the third push and falls one cycle after the pop to 2; without the macro, irq=0 throughout.
